// File: rtl/cur_buf_ctrl_pkg.sv
// Shared definitions for the current-LCU buffer controller: sizes, FSM
// encoding and the port-B read command layout.
package cur_buf_ctrl_pkg;

    localparam int PIXEL_WIDTH_DEF = 8;
    localparam int LUMA_WORDS      = 128;
    localparam int CHROMA_WORDS    = 64;
    localparam int LCU_WORDS       = LUMA_WORDS + CHROMA_WORDS;
    localparam int ADDR_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } buf_state_e;

    // Field order matches the b_* port list so a packed compare is one-to-one.
    typedef struct packed {
        logic       sel;
        logic [1:0] size;
        logic [3:0] x;
        logic [3:0] y;
        logic [4:0] idx;
    } rd_cmd_t;

endpackage

// File: rtl/cur_rd_rr_arb.sv
// Two-way round-robin arbiter for buffer read port B with registered
// per-requester read-data-valid.
module cur_rd_rr_arb
    import cur_buf_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic [1:0] rvalid
);

    // ptr=1 means r1 wins the next tie; reset favours r0.
    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= 1'b0;
            rvalid <= 2'b00;
        end else begin
            if (|gnt) begin
                ptr <= gnt[0];
            end
            rvalid <= gnt;
        end
    end

endmodule

// File: rtl/cur_buf_ctrl.sv
// Current-LCU pixel buffer controller: streams one LCU load into port A,
// then arbitrates port-B reads between two engines while idle.
module cur_buf_ctrl
    import cur_buf_ctrl_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int LOAD_WORDS  = LCU_WORDS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    output logic                      done_o,
    input  logic                      ld_valid_i,
    output logic                      ld_ready_o,
    input  logic [PIXEL_WIDTH*32-1:0] ld_data_i,
    output logic                      a_wen_o,
    output logic [ADDR_W-1:0]         a_addr_o,
    output logic [PIXEL_WIDTH*32-1:0] a_wdata_o,
    input  logic                      r0_ren_i,
    input  logic                      r0_sel_i,
    input  logic [1:0]                r0_size_i,
    input  logic [3:0]                r0_4x4_x_i,
    input  logic [3:0]                r0_4x4_y_i,
    input  logic [4:0]                r0_idx_i,
    output logic                      r0_gnt_o,
    output logic                      r0_rvalid_o,
    input  logic                      r1_ren_i,
    input  logic                      r1_sel_i,
    input  logic [1:0]                r1_size_i,
    input  logic [3:0]                r1_4x4_x_i,
    input  logic [3:0]                r1_4x4_y_i,
    input  logic [4:0]                r1_idx_i,
    output logic                      r1_gnt_o,
    output logic                      r1_rvalid_o,
    output logic                      b_ren_o,
    output logic                      b_sel_o,
    output logic [1:0]                b_size_o,
    output logic [3:0]                b_4x4_x_o,
    output logic [3:0]                b_4x4_y_o,
    output logic [4:0]                b_idx_o,
    input  logic [PIXEL_WIDTH*32-1:0] b_rdata_i,
    output logic [PIXEL_WIDTH*32-1:0] r_data_o
);

    localparam logic [ADDR_W-1:0] FULL_CNT = ADDR_W'(LOAD_WORDS);

    // Stream handshake: a word transfers on any cycle with ld_valid_i & ld_ready_o.
    buf_state_e        state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              ld_accept;
    logic              arb_en;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    rd_cmd_t           cmd0, cmd1, b_cmd;

    assign ld_accept = ld_valid_i & ld_ready_o;

    // cnt==FULL_CNT is the drain cycle carrying the last write; DONE follows it.
    always_comb begin
        state_nxt  = state;
        ld_ready_o = 1'b0;
        done_o     = 1'b0;
        arb_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                arb_en = 1'b1;
                if (start_i) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                ld_ready_o = (cnt != FULL_CNT);
                if (cnt == FULL_CNT) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done_o    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            a_wen_o   <= 1'b0;
            a_addr_o  <= '0;
            a_wdata_o <= '0;
        end else begin
            state   <= state_nxt;
            a_wen_o <= ld_accept;
            if (state == ST_IDLE && start_i) begin
                cnt <= '0;
            end else if (ld_accept) begin
                cnt <= cnt + 1'b1;
            end
            if (ld_accept) begin
                a_addr_o  <= cnt;
                a_wdata_o <= ld_data_i;
            end
        end
    end

    cur_rd_rr_arb u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (arb_en),
        .req    ({r1_ren_i, r0_ren_i}),
        .gnt    (gnt),
        .rvalid (rvalid)
    );

    assign cmd0 = '{sel: r0_sel_i, size: r0_size_i, x: r0_4x4_x_i, y: r0_4x4_y_i, idx: r0_idx_i};
    assign cmd1 = '{sel: r1_sel_i, size: r1_size_i, x: r1_4x4_x_i, y: r1_4x4_y_i, idx: r1_idx_i};

    always_comb begin
        b_cmd = '0;
        if (gnt[0])      b_cmd = cmd0;
        else if (gnt[1]) b_cmd = cmd1;
    end

    assign r0_gnt_o    = gnt[0];
    assign r1_gnt_o    = gnt[1];
    assign r0_rvalid_o = rvalid[0];
    assign r1_rvalid_o = rvalid[1];
    assign b_ren_o     = |gnt;
    assign b_sel_o     = b_cmd.sel;
    assign b_size_o    = b_cmd.size;
    assign b_4x4_x_o   = b_cmd.x;
    assign b_4x4_y_o   = b_cmd.y;
    assign b_idx_o     = b_cmd.idx;
    assign r_data_o    = b_rdata_i;

endmodule

// File: tb/tb_cur_buf_ctrl.sv
// Self-checking bench for cur_buf_ctrl: randomized loads and reads against a
// timestamp-based reference model of the load/read rules.
module tb_cur_buf_ctrl;

    localparam int DW = 256;
    localparam int NW = 192;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          done_o;
    logic          ld_valid_i = 1'b0;
    logic          ld_ready_o;
    logic [DW-1:0] ld_data_i = '0;
    logic          a_wen_o;
    logic [7:0]    a_addr_o;
    logic [DW-1:0] a_wdata_o;
    logic          r0_ren_i = 1'b0, r0_sel_i = 1'b0;
    logic [1:0]    r0_size_i = '0;
    logic [3:0]    r0_4x4_x_i = '0, r0_4x4_y_i = '0;
    logic [4:0]    r0_idx_i = '0;
    logic          r0_gnt_o, r0_rvalid_o;
    logic          r1_ren_i = 1'b0, r1_sel_i = 1'b0;
    logic [1:0]    r1_size_i = '0;
    logic [3:0]    r1_4x4_x_i = '0, r1_4x4_y_i = '0;
    logic [4:0]    r1_idx_i = '0;
    logic          r1_gnt_o, r1_rvalid_o;
    logic          b_ren_o, b_sel_o;
    logic [1:0]    b_size_o;
    logic [3:0]    b_4x4_x_o, b_4x4_y_o;
    logic [4:0]    b_idx_o;
    logic [DW-1:0] b_rdata_i = '0;
    logic [DW-1:0] r_data_o;

    always #5 clk = ~clk;

    cur_buf_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .done_o(done_o),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_data_i(ld_data_i),
        .a_wen_o(a_wen_o), .a_addr_o(a_addr_o), .a_wdata_o(a_wdata_o),
        .r0_ren_i(r0_ren_i), .r0_sel_i(r0_sel_i), .r0_size_i(r0_size_i),
        .r0_4x4_x_i(r0_4x4_x_i), .r0_4x4_y_i(r0_4x4_y_i), .r0_idx_i(r0_idx_i),
        .r0_gnt_o(r0_gnt_o), .r0_rvalid_o(r0_rvalid_o),
        .r1_ren_i(r1_ren_i), .r1_sel_i(r1_sel_i), .r1_size_i(r1_size_i),
        .r1_4x4_x_i(r1_4x4_x_i), .r1_4x4_y_i(r1_4x4_y_i), .r1_idx_i(r1_idx_i),
        .r1_gnt_o(r1_gnt_o), .r1_rvalid_o(r1_rvalid_o),
        .b_ren_o(b_ren_o), .b_sel_o(b_sel_o), .b_size_o(b_size_o),
        .b_4x4_x_o(b_4x4_x_o), .b_4x4_y_o(b_4x4_y_o), .b_idx_o(b_idx_o),
        .b_rdata_i(b_rdata_i), .r_data_o(r_data_o)
    );

    // Scoreboard and reference model: a load is a window of cycles, writes
    // are timestamped one cycle after their accept, reads follow round-robin.
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    bit            m_busy = 1'b0;
    int            m_nacc = 0;
    int            m_last_acc = -100;
    int            m_pref = 0;
    bit [1:0]      m_prev_gnt = 2'b00;
    logic [DW-1:0] exp_q[$];
    logic [7:0]    exp_addr_q[$];
    int            exp_due_q[$];
    int            n_wr_seen = 0;
    int            n_done_seen = 0;
    int            data_base = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy     = 1'b0;
        m_nacc     = 0;
        m_last_acc = -100;
        m_pref     = 0;
        m_prev_gnt = 2'b00;
        exp_q.delete();
        exp_addr_q.delete();
        exp_due_q.delete();
    endtask

    task automatic rand_reqs(input int p0, input int p1);
        r0_ren_i   = ($urandom_range(0, 99) < p0);
        r1_ren_i   = ($urandom_range(0, 99) < p1);
        r0_sel_i   = 1'($urandom);
        r0_size_i  = 2'($urandom);
        r0_4x4_x_i = 4'($urandom);
        r0_4x4_y_i = 4'($urandom);
        r0_idx_i   = 5'($urandom);
        r1_sel_i   = 1'($urandom);
        r1_size_i  = 2'($urandom);
        r1_4x4_x_i = 4'($urandom);
        r1_4x4_y_i = 4'($urandom);
        r1_idx_i   = 5'($urandom);
        b_rdata_i  = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
    endtask

    // One clock: compare at the falling edge, advance the model, return just
    // after the rising edge so the caller can drive the next inputs.
    task automatic tick();
        bit [1:0]   req, g;
        bit         exp_ready, exp_done, acc;
        logic [15:0] exp_b, obs_b;
        @(negedge clk);
        req       = {r1_ren_i, r0_ren_i};
        exp_ready = m_busy && (m_nacc < NW);
        exp_done  = m_busy && (m_nacc == NW) && (cyc == m_last_acc + 2);
        g = 2'b00;
        if (!m_busy) begin
            if (req == 2'b11) g = (m_pref == 1) ? 2'b10 : 2'b01;
            else              g = req;
        end
        if (g[0])      exp_b = {r0_sel_i, r0_size_i, r0_4x4_x_i, r0_4x4_y_i, r0_idx_i};
        else if (g[1]) exp_b = {r1_sel_i, r1_size_i, r1_4x4_x_i, r1_4x4_y_i, r1_idx_i};
        else           exp_b = '0;
        obs_b = {b_sel_o, b_size_o, b_4x4_x_o, b_4x4_y_o, b_idx_o};

        chk("ld_ready", ld_ready_o, exp_ready);
        chk("done", done_o, exp_done);
        chk("gnt", {r1_gnt_o, r0_gnt_o}, g);
        chk("rvalid", {r1_rvalid_o, r0_rvalid_o}, m_prev_gnt);
        chk("b_ren", b_ren_o, |g);
        chk("b_cmd", obs_b, exp_b);
        chk("r_data", r_data_o, b_rdata_i);
        if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
            chk("a_wen", a_wen_o, 1'b1);
            chk("a_addr", a_addr_o, exp_addr_q[0]);
            chk("a_wdata", a_wdata_o, exp_q[0]);
            void'(exp_due_q.pop_front());
            void'(exp_addr_q.pop_front());
            void'(exp_q.pop_front());
        end else begin
            chk("a_wen_idle", a_wen_o, 1'b0);
        end
        if (a_wen_o) n_wr_seen++;
        if (done_o)  n_done_seen++;

        acc = exp_ready && ld_valid_i;
        if (acc) begin
            exp_q.push_back(ld_data_i);
            exp_addr_q.push_back(8'(m_nacc));
            exp_due_q.push_back(cyc + 1);
            m_nacc++;
            if (m_nacc == NW) m_last_acc = cyc;
        end
        if (exp_done)                  m_busy = 1'b0;
        else if (!m_busy && start_i) begin
            m_busy = 1'b1;
            m_nacc = 0;
        end
        if (g != 2'b00) m_pref = g[0] ? 1 : 0;
        m_prev_gnt = g;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_wen"}, a_wen_o, 1'b0);
        chk({tag, "_addr"}, a_addr_o, 8'h00);
        chk({tag, "_wdata"}, a_wdata_o, '0);
        chk({tag, "_done"}, done_o, 1'b0);
        chk({tag, "_ready"}, ld_ready_o, 1'b0);
        chk({tag, "_rvalid"}, {r1_rvalid_o, r0_rvalid_o}, 2'b00);
        chk({tag, "_gnt"}, {r1_gnt_o, r0_gnt_o, b_ren_o}, 3'b000);
        chk({tag, "_bcmd"}, {b_sel_o, b_size_o, b_4x4_x_o, b_4x4_y_o, b_idx_o}, 16'h0);
    endtask

    // Asserted mid-cycle so the outputs must clear without a clock edge.
    task automatic apply_reset(input string tag);
        r0_ren_i   = 1'b0;
        r1_ren_i   = 1'b0;
        start_i    = 1'b0;
        ld_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        zero_check(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    // mode 0: valid held high, incrementing data; 1: valid toggles with
    // stray start pulses; 2: random valid. Returns early at abort_at words.
    task automatic run_load(input int mode, input int abort_at, input int hold_r1);
        int guard;
        n_wr_seen   = 0;
        n_done_seen = 0;
        rand_reqs(30, hold_r1 ? 100 : 30);
        start_i    = 1'b1;
        ld_valid_i = 1'b0;
        tick();
        start_i = 1'b0;
        guard = 0;
        while (m_busy && guard < 700) begin
            if (abort_at >= 0 && m_nacc == abort_at) return;
            case (mode)
                0:       ld_valid_i = 1'b1;
                1:       ld_valid_i = (guard % 2 == 0);
                default: ld_valid_i = ($urandom_range(0, 3) != 0);
            endcase
            ld_data_i = (mode == 0) ? {8{32'(data_base + m_nacc)}}
                                    : {$urandom, $urandom, $urandom, $urandom,
                                       $urandom, $urandom, $urandom, $urandom};
            start_i = (mode == 1) && ($urandom_range(0, 9) == 0);
            rand_reqs(40, hold_r1 ? 100 : 40);
            tick();
            guard++;
        end
        ld_valid_i = 1'b0;
        start_i    = 1'b0;
        rand_reqs(0, hold_r1 ? 100 : 0);
        tick();
        chk("done_count", n_done_seen, 1);
        chk("wr_count", n_wr_seen, NW);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        zero_check("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        // Contention from reset: grants must alternate starting with r0.
        for (int i = 0; i < 6; i++) begin
            rand_reqs(100, 100);
            tick();
        end
        rand_reqs(0, 0);
        tick();

        data_base = 32'h1000;
        run_load(0, -1, 0);
        run_load(1, -1, 1);

        run_load(2, 100, 0);
        apply_reset("mid_load_rst");
        run_load(2, -1, 0);

        // Start and an r1 request together in IDLE.
        rand_reqs(0, 100);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        rand_reqs(0, 0);
        ld_valid_i = 1'b1;
        tick();
        n_wr_seen   = 1;
        n_done_seen = 0;
        while (m_busy && cyc < 20000) begin
            ld_data_i = {8{$urandom}};
            rand_reqs(50, 50);
            tick();
        end
        ld_valid_i = 1'b0;
        tick();
        chk("done_count_sr", n_done_seen, 1);

        for (int i = 0; i < 60; i++) begin
            rand_reqs(60, 60);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
